// File: rtl/mmio_periph_hub.sv
`default_nettype none
// =============================================================================
// mmio_periph_hub : decoded MMIO window (cycle/event counters, UART TX FIFO)
//                   in front of dmem; optional compare IRQ via PERIPH_CMP_IRQ_EN
// Revision        : 1.0
// =============================================================================
module mmio_periph_hub #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          NUM_CNT    = 2,
    parameter int          CNT_WIDTH  = 32,
    parameter int          UART_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    input  logic               wen_i,
    input  logic [2:0]         size_i,
    input  logic [31:0]        mem_rdata_i,
    output logic [31:0]        rdata_o,
    output logic               mem_wen_o,
    input  logic [NUM_CNT-1:0] cnt_event_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i
`ifdef PERIPH_CMP_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    localparam int AW = $clog2(UART_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [5:0]    OFF_CNT_EN  = 6'h10;
    localparam logic [5:0]    OFF_CNT_CLR = 6'h11;
    localparam logic [5:0]    OFF_CMP     = 6'h12;
    localparam logic [5:0]    OFF_CYCLE   = 6'h3C;
    localparam logic [5:0]    OFF_STATUS  = 6'h3E;
    localparam logic [5:0]    OFF_TX      = 6'h3F;
    localparam logic [OW-1:0] FULL_OCC    = OW'(UART_DEPTH);

    logic                 w_hit, w_wr, w_stat_wr;
    logic [5:0]           w_off;
    logic                 w_empty, w_full, w_push_req, w_push, w_pop;
    logic                 w_cmp_en, w_irq;
    logic [CNT_WIDTH-1:0] w_cmp;
    logic [31:0]          w_reg;
    logic                 w_unused;

    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [NUM_CNT-1:0]   en_q;
    logic [7:0]           fifo_q [UART_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]        occ_q, occ_d;
    logic                 ovf_q;

    assign w_hit     = (addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off     = addr_i[7:2];
    assign w_wr      = wen_i & w_hit;
    assign w_stat_wr = w_wr & (w_off == OFF_STATUS);
    assign mem_wen_o = wen_i & ~w_hit;
    assign w_unused  = ^{size_i, addr_i[1:0], wdata_i};

    // A register write in the same cycle as an increment takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            en_q    <= '0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (w_wr && w_off == OFF_CNT_EN) en_q <= wdata_i[NUM_CNT-1:0];
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_wr && w_off == 6'(i))
                    cnt_q[i] <= wdata_i[CNT_WIDTH-1:0];
                else if (w_wr && w_off == OFF_CNT_CLR && wdata_i[i])
                    cnt_q[i] <= '0;
                else if (en_q[i] && cnt_event_i[i])
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    assign w_empty    = (occ_q == '0);
    assign w_full     = (occ_q == FULL_OCC);
    assign w_push_req = w_wr & (w_off == OFF_TX);
    assign w_push     = w_push_req & ~w_full;
    assign w_pop      = ~w_empty & tx_ready_i;
    assign tx_valid_o = ~w_empty;
    assign tx_data_o  = fifo_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        if (w_push && !w_pop)
            occ_d = occ_q + OW'(1);
        else if (!w_push && w_pop)
            occ_d = occ_q - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) fifo_q[wr_ptr_q] <= wdata_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q <= occ_d;
            if (w_push_req && w_full)
                ovf_q <= 1'b1;
            else if (w_stat_wr && wdata_i[2])
                ovf_q <= 1'b0;
        end
    end

`ifdef PERIPH_CMP_IRQ_EN
    logic [CNT_WIDTH-1:0] cmp_q;
    logic                 cmp_en_q, irq_q;

    // Compare uses the pre-increment cycle value; a match beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q    <= '0;
            cmp_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (w_wr && w_off == OFF_CMP)    cmp_q    <= wdata_i[CNT_WIDTH-1:0];
            if (w_wr && w_off == OFF_CNT_EN) cmp_en_q <= wdata_i[31];
            if (cmp_en_q && cycle_q == cmp_q)
                irq_q <= 1'b1;
            else if (w_stat_wr && wdata_i[3])
                irq_q <= 1'b0;
        end
    end

    assign irq_o    = irq_q;
    assign w_cmp_en = cmp_en_q;
    assign w_irq    = irq_q;
    assign w_cmp    = cmp_q;
`else
    assign w_cmp_en = 1'b0;
    assign w_irq    = 1'b0;
    assign w_cmp    = '0;
`endif

    always_comb begin
        w_reg = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (w_off == 6'(i)) w_reg[CNT_WIDTH-1:0] = cnt_q[i];
        case (w_off)
            OFF_CNT_EN: begin
                w_reg[NUM_CNT-1:0] = en_q;
                w_reg[31]          = w_cmp_en;
            end
            OFF_CMP:    w_reg[CNT_WIDTH-1:0] = w_cmp;
            OFF_CYCLE:  w_reg[CNT_WIDTH-1:0] = cycle_q;
            OFF_STATUS: begin
                w_reg[0]      = w_empty;
                w_reg[1]      = w_full;
                w_reg[2]      = ovf_q;
                w_reg[3]      = w_irq;
                w_reg[8 +: OW] = occ_q;
            end
            default: ;
        endcase
    end

    assign rdata_o = w_hit ? w_reg : mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mmio_periph_hub.sv
`default_nettype none
// =============================================================================
// tb_mmio_periph_hub : directed bench for mmio_periph_hub (UART_DEPTH=4)
// Revision           : 1.0
// =============================================================================
module tb_mmio_periph_hub;

    localparam int          NUM_CNT    = 2;
    localparam int          CNT_WIDTH  = 32;
    localparam int          UART_DEPTH = 4;
    localparam logic [31:0] A_CNT0 = 32'hFFFF_FF00;
    localparam logic [31:0] A_CNT1 = 32'hFFFF_FF04;
    localparam logic [31:0] A_EN   = 32'hFFFF_FF40;
    localparam logic [31:0] A_CLR  = 32'hFFFF_FF44;
    localparam logic [31:0] A_CMP  = 32'hFFFF_FF48;
    localparam logic [31:0] A_CYC  = 32'hFFFF_FFF0;
    localparam logic [31:0] A_STAT = 32'hFFFF_FFF8;
    localparam logic [31:0] A_TX   = 32'hFFFF_FFFC;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        addr = '0;
    logic [31:0]        wdata = '0;
    logic               wen = 1'b0;
    logic [2:0]         size = 3'b010;
    logic [31:0]        mem_rdata = '0;
    logic [31:0]        rdata;
    logic               mem_wen;
    logic [NUM_CNT-1:0] cnt_event = '0;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
`ifdef PERIPH_CMP_IRQ_EN
    logic               irq;
`endif

    int          checks = 0;
    int          passed = 0;
    logic [31:0] d;

    mmio_periph_hub #(
        .BASE_ADDR (32'hFFFF_FF00),
        .NUM_CNT   (NUM_CNT),
        .CNT_WIDTH (CNT_WIDTH),
        .UART_DEPTH(UART_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .wen_i      (wen),
        .size_i     (size),
        .mem_rdata_i(mem_rdata),
        .rdata_o    (rdata),
        .mem_wen_o  (mem_wen),
        .cnt_event_i(cnt_event),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready)
`ifdef PERIPH_CMP_IRQ_EN
        ,
        .irq_o      (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        addr = a; wdata = v; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        addr = a; wen = 1'b0;
        #1 v = rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        addr = A_CYC; #1;
        checks++; if (rdata !== 32'd0) $display("FAIL reset_cycle: got %h want %h", rdata, 32'd0); else passed++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else passed++;
        addr = A_STAT; #1;
        checks++; if (rdata !== 32'h1) $display("FAIL reset_status: got %h want %h", rdata, 32'h1); else passed++;
        addr = A_EN; #1;
        checks++; if (rdata !== 32'h0) $display("FAIL reset_cnt_en: got %h want %h", rdata, 32'h0); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        addr = 32'h0000_0100; wdata = 32'h1234; wen = 1'b1; mem_rdata = 32'hCAFE_BABE; #1;
        checks++; if (mem_wen !== 1'b1) $display("FAIL pass_mem_wen: got %b want 1", mem_wen); else passed++;
        checks++; if (rdata !== 32'hCAFE_BABE) $display("FAIL pass_rdata: got %h want %h", rdata, 32'hCAFE_BABE); else passed++;
        addr = A_EN; #1;
        checks++; if (mem_wen !== 1'b0) $display("FAIL window_mem_wen: got %b want 0", mem_wen); else passed++;
        wen = 1'b0;
        @(negedge clk);
        addr = 32'h0000_0100; mem_rdata = 32'h1111_2222; #1;
        checks++; if (rdata !== 32'h1111_2222) $display("FAIL pass_rdata2: got %h want %h", rdata, 32'h1111_2222); else passed++;
        addr = 32'hFFFF_FF80; #1;
        checks++; if (rdata !== 32'h0) $display("FAIL unmapped_read: got %h want %h", rdata, 32'h0); else passed++;
    endtask

    task automatic test_cycle();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; addr = A_CYC; wen = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rdata !== 32'd10) $display("FAIL cycle_10: got %0d want 10", rdata); else passed++;
        @(negedge clk); wdata = 32'hDEAD; wen = 1'b1;
        @(negedge clk); wen = 1'b0; #1;
        checks++; if (rdata !== 32'd11) $display("FAIL cycle_ro: got %0d want 11", rdata); else passed++;
        @(negedge clk); #1;
        checks++; if (rdata !== 32'd12) $display("FAIL cycle_inc: got %0d want 12", rdata); else passed++;
    endtask

    task automatic test_event_cnt();
        wr(A_EN, 32'h1);
        rd(A_EN, d);
        checks++; if (d !== 32'h1) $display("FAIL cnt_en_rd: got %h want %h", d, 32'h1); else passed++;
        @(negedge clk); cnt_event = 2'b11;
        repeat (5) @(negedge clk);
        cnt_event = 2'b00;
        rd(A_CNT0, d);
        checks++; if (d !== 32'd5) $display("FAIL cnt0_events: got %0d want 5", d); else passed++;
        rd(A_CNT1, d);
        checks++; if (d !== 32'd0) $display("FAIL cnt1_disabled: got %0d want 0", d); else passed++;
        wr(A_CLR, 32'h1);
        rd(A_CNT0, d);
        checks++; if (d !== 32'd0) $display("FAIL cnt0_clr: got %0d want 0", d); else passed++;
        rd(A_CLR, d);
        checks++; if (d !== 32'd0) $display("FAIL clr_reads0: got %h want 0", d); else passed++;
        // load all-ones while an event arrives: the load wins, the next event wraps
        @(negedge clk); addr = A_CNT0; wdata = 32'hFFFF_FFFF; wen = 1'b1; cnt_event = 2'b01;
        @(negedge clk); wen = 1'b0; #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL cnt0_load: got %h want %h", rdata, 32'hFFFF_FFFF); else passed++;
        @(negedge clk); #1;
        checks++; if (rdata !== 32'h0) $display("FAIL cnt0_wrap: got %h want 0", rdata); else passed++;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rdata !== 32'd3) $display("FAIL cnt0_count3: got %0d want 3", rdata); else passed++;
        addr = A_CLR; wdata = 32'h1; wen = 1'b1;
        @(negedge clk); wen = 1'b0; cnt_event = 2'b00; addr = A_CNT0; #1;
        checks++; if (rdata !== 32'd0) $display("FAIL clr_beats_inc: got %0d want 0", rdata); else passed++;
    endtask

    task automatic test_uart_fill_drain();
        tx_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h45; b++) wr(A_TX, 32'(b));
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) $display("FAIL fill_head: got v=%b d=%h want v=1 d=41", tx_valid, tx_data); else passed++;
        rd(A_STAT, d);
        checks++; if (d !== 32'h0000_0406) $display("FAIL fill_status: got %h want %h", d, 32'h0000_0406); else passed++;
        rd(A_TX, d);
        checks++; if (d !== 32'h0) $display("FAIL tx_reads0: got %h want 0", d); else passed++;
        @(negedge clk); tx_ready = 1'b1; #1;
        checks++; if (tx_data !== 8'h41) $display("FAIL drain_0: got %h want 41", tx_data); else passed++;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + k)) $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, 8'(8'h41 + k)); else passed++;
        end
        @(negedge clk); #1;
        checks++; if (tx_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", tx_valid); else passed++;
        tx_ready = 1'b0;
        rd(A_STAT, d);
        checks++; if (d !== 32'h5) $display("FAIL drained_status: got %h want %h", d, 32'h5); else passed++;
        wr(A_STAT, 32'h4);
        rd(A_STAT, d);
        checks++; if (d !== 32'h1) $display("FAIL ovf_clear: got %h want %h", d, 32'h1); else passed++;
    endtask

    task automatic test_push_pop();
        wr(A_TX, 32'h61);
        wr(A_TX, 32'h62);
        rd(A_STAT, d);
        checks++; if (d !== 32'h0200) $display("FAIL pp_occ2: got %h want %h", d, 32'h0200); else passed++;
        @(negedge clk); addr = A_TX; wdata = 32'h55; wen = 1'b1; tx_ready = 1'b1;
        @(negedge clk); wen = 1'b0; tx_ready = 1'b0; addr = A_STAT; #1;
        checks++; if (rdata !== 32'h0200) $display("FAIL pp_occ_hold: got %h want %h", rdata, 32'h0200); else passed++;
        checks++; if (tx_data !== 8'h62) $display("FAIL pp_head: got %h want 62", tx_data); else passed++;
        tx_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (tx_data !== 8'h55) $display("FAIL pp_order: got %h want 55", tx_data); else passed++;
        @(negedge clk); #1;
        checks++; if (tx_valid !== 1'b0) $display("FAIL pp_empty: got %b want 0", tx_valid); else passed++;
        tx_ready = 1'b0;
        // full FIFO: push is dropped even when a pop happens the same cycle
        for (int b = 8'h71; b <= 8'h74; b++) wr(A_TX, 32'(b));
        @(negedge clk); addr = A_TX; wdata = 32'h75; wen = 1'b1; tx_ready = 1'b1;
        @(negedge clk); wen = 1'b0; tx_ready = 1'b0; addr = A_STAT; #1;
        checks++; if (rdata !== 32'h0304) $display("FAIL fullpop_status: got %h want %h", rdata, 32'h0304); else passed++;
        checks++; if (tx_data !== 8'h72) $display("FAIL fullpop_head: got %h want 72", tx_data); else passed++;
        tx_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (tx_data !== 8'h74) $display("FAIL fullpop_last: got %h want 74", tx_data); else passed++;
        @(negedge clk); #1;
        checks++; if (tx_valid !== 1'b0) $display("FAIL fullpop_dropped: got %b want 0", tx_valid); else passed++;
        tx_ready = 1'b0;
        wr(A_STAT, 32'h4);
    endtask

    task automatic test_reset_mid();
        wr(A_TX, 32'h81);
        wr(A_TX, 32'h82);
        wr(A_TX, 32'h83);
        wr(A_EN, 32'h1);
        @(negedge clk); cnt_event = 2'b01;
        repeat (2) @(negedge clk);
        cnt_event = 2'b00;
        rd(A_CNT0, d);
        checks++; if (d !== 32'd2) $display("FAIL pre_rst_cnt0: got %0d want 2", d); else passed++;
        rd(A_STAT, d);
        checks++; if (d !== 32'h0300) $display("FAIL pre_rst_status: got %h want %h", d, 32'h0300); else passed++;
        @(negedge clk); rst = 1'b1; addr = 32'h0000_0200; wdata = 32'h99; wen = 1'b1; mem_rdata = 32'h5A5A_0001; #1;
        checks++; if (mem_wen !== 1'b1 || rdata !== 32'h5A5A_0001) $display("FAIL rst_passthru: got wen=%b rd=%h want wen=1 rd=5a5a0001", mem_wen, rdata); else passed++;
        addr = A_TX;
        @(negedge clk); rst = 1'b0; wen = 1'b0; addr = A_STAT; #1;
        checks++; if (rdata !== 32'h1 || tx_valid !== 1'b0) $display("FAIL rst_fifo: got st=%h v=%b want st=1 v=0", rdata, tx_valid); else passed++;
        addr = A_CYC; #1;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_cycle: got %h want 0", rdata); else passed++;
        addr = A_CNT0; #1;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_cnt0: got %h want 0", rdata); else passed++;
        addr = A_EN; #1;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_cnt_en: got %h want 0", rdata); else passed++;
    endtask

`ifdef PERIPH_CMP_IRQ_EN
    task automatic test_cmp_irq();
        logic found;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wr(A_CMP, 32'd20);
        wr(A_EN, 32'h8000_0000);
        rd(A_CMP, d);
        checks++; if (d !== 32'd20) $display("FAIL cmp_rd: got %0d want 20", d); else passed++;
        rd(A_EN, d);
        checks++; if (d !== 32'h8000_0000) $display("FAIL cmp_en_rd: got %h want %h", d, 32'h8000_0000); else passed++;
        addr = A_CYC;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk); #1;
            if (rdata == 32'd20) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL cycle20_timeout: got cycle %0d want 20", rdata); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL irq_early: got %b want 0", irq); else passed++;
        @(negedge clk); #1;
        checks++; if (rdata !== 32'd21 || irq !== 1'b1) $display("FAIL irq_set: got cyc=%0d irq=%b want cyc=21 irq=1", rdata, irq); else passed++;
        rd(A_STAT, d);
        checks++; if (d !== 32'h9) $display("FAIL irq_status: got %h want %h", d, 32'h9); else passed++;
        wr(A_STAT, 32'h8);
        #1;
        checks++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else passed++;
    endtask
`else
    task automatic test_cmp_absent();
        wr(A_CMP, 32'd20);
        rd(A_CMP, d);
        checks++; if (d !== 32'h0) $display("FAIL cmp_absent: got %h want 0", d); else passed++;
        wr(A_EN, 32'h8000_0001);
        rd(A_EN, d);
        checks++; if (d !== 32'h1) $display("FAIL en_bit31_absent: got %h want %h", d, 32'h1); else passed++;
        rd(A_STAT, d);
        checks++; if (d !== 32'h1) $display("FAIL status_bit3_absent: got %h want %h", d, 32'h1); else passed++;
        wr(A_EN, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_cycle();
        test_event_cnt();
        test_uart_fill_drain();
        test_push_pop();
        test_reset_mid();
`ifdef PERIPH_CMP_IRQ_EN
        test_cmp_irq();
`else
        test_cmp_absent();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_periph_hub.md
Name: mmio_periph_hub

Overview:
Parametrised memory-mapped peripheral hub between the core data port and dmem. It replaces the fixed UART-at-FFFF_FFFC and timer-at-FFFF_FFF0 decode with a single decoded window containing:
- a free-running cycle counter;
- NUM_CNT event counters with enable and clear;
- a buffered UART TX FIFO with a valid/ready drain port.

Accesses outside the window pass through to dmem unchanged.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, 256-byte window base; must be 256-byte aligned.
NUM_CNT, 2, number of event counters, 1..8.
CNT_WIDTH, 32, width of the cycle counter and event counters, 1..32; reads zero-extend to 32 bits.
UART_DEPTH, 16, TX FIFO entries; power of 2, 2..128.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  32  core data address
wdata  in  32  core write data
wen  in  1  core write enable
size  in  3  core access size; passed through, ignored in window
mem_rdata  in  32  dmem read data
rdata  out  32  read data returned to core
mem_wen  out  1  dmem write enable
cnt_event  in  NUM_CNT  per-counter event strobes
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  sink accepts head byte

Behaviour:
Decode and pass-through:
- hit = (addr[31:8] == BASE_ADDR[31:8]); addr[1:0] ignored; word access only.
- mem_wen = wen & ~hit.
- rdata is combinational: the register value if hit, else mem_rdata. Unmapped offsets read 0 and ignore writes.

Register map (offsets):
- 0x00+4*i, i<NUM_CNT: CNT_i. Read returns the value; a write loads wdata[CNT_WIDTH-1:0].
- 0x40 CNT_EN: bit i enables CNT_i. Read/write.
- 0x44 CNT_CLR: write-only; each bit set zeroes CNT_i. Reads 0.
- 0xF0 CYCLE: read-only cycle count; writes ignored.
- 0xF8 UART_STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] occupancy.
  - Writing with bit2=1 clears overflow.
- 0xFC UART_TX: a write pushes wdata[7:0]. Reads 0.

Counters:
- CYCLE increments every cycle after reset.
- CNT_i increments when CNT_EN[i] & cnt_event[i].
- All counters wrap from 2^CNT_WIDTH-1 to 0.
- A register write (load or clear) in the same cycle as an increment wins: the written value is stored and the increment is lost.

UART FIFO:
- Push on a write to UART_TX.
- Pop when tx_valid & tx_ready.
- tx_valid = ~empty; tx_data = mem[rd_ptr]. Both derive from registered state only.
- Push while full (full judged on pre-cycle occupancy): byte dropped, overflow set. This holds even if a pop occurs in the same cycle.
- Push and pop in the same cycle while not full: occupancy unchanged.
- Push when empty: tx_valid rises the next cycle.
- Pointers wrap modulo UART_DEPTH.
- Occupancy is held in log2(UART_DEPTH)+1 bits.

Reset (synchronous, active-high; takes priority over every access in that cycle):
- CYCLE, all CNT_i, CNT_EN, pointers, occupancy and overflow go to 0; tx_valid=0.
- FIFO contents are not cleared and are don't-care.
- Reset mid-drain discards all queued bytes.
- mem_wen and rdata stay combinational and follow their inputs.

Latency:
- Register reads: 0 cycles.
- Writes take effect at the next clk edge.

Optional Feature:
Macro PERIPH_CMP_IRQ_EN.

Defined:
- Adds an output port irq (1 bit).
- Adds register 0x48 CMP (read/write, CNT_WIDTH bits, reset 0).
- Adds CNT_EN bit 31 as the compare enable.
- Adds UART_STATUS bit3 as the irq mirror.
- When CNT_EN[31] is set and CYCLE == CMP (pre-increment value), irq sets the next cycle and stays sticky.
- Writing UART_STATUS with bit3=1 clears irq. If the clear and the set happen in the same cycle, set wins.
- irq resets to 0.

Undefined:
- No irq port.
- 0x48 reads 0 and ignores writes.
- CNT_EN bit 31 is unimplemented and reads 0.
- STATUS bit3 reads 0.

Test Plan:
1. Pass-through: write 0x1234 to addr 0x0000_0100 with wen=1 -> mem_wen=1. Write to 0xFFFF_FF40 -> mem_wen=0. Read of 0x100 returns mem_rdata.
2. Cycle counter: release rst, wait 10 edges, read 0xFFFF_FFF0 -> 10. Write 0xDEAD there -> value unaffected, still incrementing.
3. Event counters, NUM_CNT=2:
   - Write CNT_EN=0x1, pulse cnt_event=2'b11 for 5 cycles -> CNT_0=5, CNT_1=0.
   - Write CNT_CLR=0x1 -> CNT_0=0.
   - Load CNT_0=32'hFFFF_FFFF with an event pending next cycle -> wraps to 0.
4. UART FIFO, UART_DEPTH=4, tx_ready=0:
   - Push 0x41..0x45 -> 4 stored, STATUS = full=1, overflow=1, occupancy=4.
   - Raise tx_ready -> tx_data emits 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid=0, empty=1.
   - Write STATUS bit2 -> overflow=0.
5. Simultaneous push/pop: occupancy=2, push 0x55 while popping -> occupancy stays 2, byte order preserved.
6. Reset mid-operation: FIFO occupancy 3, CNT_EN=1, assert rst for 1 cycle -> tx_valid=0, occupancy=0, all counters 0, CNT_EN=0. With PERIPH_CMP_IRQ_EN: CMP=20, CNT_EN[31]=1 -> irq rises after CYCLE reaches 20; write STATUS bit3 -> irq clears.
